// File: rtl/branch_cond_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit_if
// Purpose  : Decode/fetch-side bundle for the branch condition unit: CC writes,
//            branch request handshake, delay-slot sequencing and results.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_cond_unit_if #(
    parameter int SEL_W = 1,
    parameter int CNT_W = 16
);
    logic             cc_we;
    logic [SEL_W-1:0] cc_wsel;
    logic [3:0]       cc_wdata;
    logic             br_valid;
    logic             br_ready;
    logic [3:0]       br_cond;
    logic             br_annul;
    logic [SEL_W-1:0] br_sel;
    logic             slot_valid;
    logic             flush;
    logic             res_valid;
    logic             res_taken;
    logic             res_annul;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] total_cnt;

    modport master (
        output cc_we, cc_wsel, cc_wdata,
        output br_valid, br_cond, br_annul, br_sel,
        output slot_valid, flush,
        input  br_ready, res_valid, res_taken, res_annul, taken_cnt, total_cnt
    );

    modport slave (
        input  cc_we, cc_wsel, cc_wdata,
        input  br_valid, br_cond, br_annul, br_sel,
        input  slot_valid, flush,
        output br_ready, res_valid, res_taken, res_annul, taken_cnt, total_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit
// Purpose  : Bicc evaluation against banked integer condition codes with
//            same-cycle forwarding, registered taken/annul and delay-slot FSM.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond_unit #(
    parameter int NUM_CC = 2,
    parameter int SEL_W  = (NUM_CC > 1) ? $clog2(NUM_CC) : 1,
    parameter int CNT_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    branch_cond_unit_if.slave bus
);

    localparam logic [3:0] c_cond_ba = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cc [NUM_CC];
    logic [3:0]       w_flags;
    logic             w_base;
    logic             w_taken;
    logic             w_annul;
    logic             w_ready;
    logic             w_accept;
    logic             r_res_valid;
    logic             r_res_taken;
    logic             r_res_annul;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_total_cnt;

    // Out-of-range selects match no bank: writes drop, reads see all-zero flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CC; i++) r_cc[i] <= '0;
        end else if (bus.cc_we) begin
            for (int i = 0; i < NUM_CC; i++) begin
                if (bus.cc_wsel == SEL_W'(i)) r_cc[i] <= bus.cc_wdata;
            end
        end
    end

    always_comb begin
        w_flags = '0;
        for (int i = 0; i < NUM_CC; i++) begin
            if (bus.br_sel == SEL_W'(i)) begin
                w_flags = (bus.cc_we && (bus.cc_wsel == bus.br_sel)) ? bus.cc_wdata : r_cc[i];
            end
        end
    end

    // Low three bits pick the test, bit 3 inverts it ({N,Z,V,C} = w_flags[3:0]).
    always_comb begin
        w_base = 1'b0;
        case (bus.br_cond[2:0])
            3'd0:    w_base = 1'b0;
            3'd1:    w_base = w_flags[2];
            3'd2:    w_base = w_flags[2] | (w_flags[3] ^ w_flags[1]);
            3'd3:    w_base = w_flags[3] ^ w_flags[1];
            3'd4:    w_base = w_flags[0] | w_flags[2];
            3'd5:    w_base = w_flags[0];
            3'd6:    w_base = w_flags[3];
            default: w_base = w_flags[1];
        endcase
        w_taken = w_base ^ bus.br_cond[3];
        w_annul = bus.br_annul && (!w_taken || (bus.br_cond == c_cond_ba));
    end

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = bus.br_valid && w_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)       w_state_nxt = ST_SLOT;
                ST_SLOT: if (bus.slot_valid) w_state_nxt = ST_IDLE;
                default:                     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_taken <= 1'b0;
            r_res_annul <= 1'b0;
            r_taken_cnt <= '0;
            r_total_cnt <= '0;
        end else begin
            r_res_valid <= w_accept;
            if (w_accept) begin
                r_res_taken <= w_taken;
                r_res_annul <= w_annul;
                r_total_cnt <= r_total_cnt + 1'b1;
                if (w_taken) r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign bus.br_ready  = w_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_taken = r_res_taken;
    assign bus.res_annul = r_res_annul;
    assign bus.taken_cnt = r_taken_cnt;
    assign bus.total_cnt = r_total_cnt;

endmodule
`default_nettype wire
